// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared encodings for the memory refill arbiter
// Purpose: FSM state and burst-owner encodings plus the line-alignment helper
//   used by mem_refill_arbiter and mem_arb_pick.
// Ports: none (package).
package mem_arb_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_BURST = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;

   localparam logic [1:0] OWN_NONE = 2'd0;
   localparam logic [1:0] OWN_IC   = 2'd1;
   localparam logic [1:0] OWN_DC   = 2'd2;

   // Clears the byte-in-line bits so every burst starts at word 0 of the line.
   function automatic logic [31:0] lineBase(input logic [31:0] addr, input int lineWords);
      return addr & ~(32'(lineWords * 4) - 32'd1);
   endfunction

endpackage

// File: rtl/mem_refill_arbiter_if.sv
// rtl/mem_refill_arbiter_if.sv - cache/memory bus bundle for the refill arbiter
// Purpose: groups the I-cache, D-cache and main-memory handshake signals.
// Ports (modport master = arbiter view, slave = caches/memory view):
//   ic_req/ic_addr -> ic_rvalid/ic_rdata/ic_done
//   dc_req/dc_we/dc_addr/dc_wdata -> dc_wnext/dc_rvalid/dc_rdata/dc_done
//   mem_req/mem_we/mem_addr/mem_wdata <- mem_ack/mem_rdata, busy
interface mem_refill_arbiter_if;

   logic        ic_req;
   logic [31:0] ic_addr;
   logic        ic_rvalid;
   logic [31:0] ic_rdata;
   logic        ic_done;
   logic        dc_req;
   logic        dc_we;
   logic [31:0] dc_addr;
   logic [31:0] dc_wdata;
   logic        dc_wnext;
   logic        dc_rvalid;
   logic [31:0] dc_rdata;
   logic        dc_done;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_ack;
   logic [31:0] mem_rdata;
   logic        busy;

   modport master (
      input  ic_req, ic_addr, dc_req, dc_we, dc_addr, dc_wdata, mem_ack, mem_rdata,
      output ic_rvalid, ic_rdata, ic_done, dc_wnext, dc_rvalid, dc_rdata, dc_done,
             mem_req, mem_we, mem_addr, mem_wdata, busy
   );

   modport slave (
      output ic_req, ic_addr, dc_req, dc_we, dc_addr, dc_wdata, mem_ack, mem_rdata,
      input  ic_rvalid, ic_rdata, ic_done, dc_wnext, dc_rvalid, dc_rdata, dc_done,
             mem_req, mem_we, mem_addr, mem_wdata, busy
   );

endinterface

// File: rtl/mem_arb_pick.sv
// rtl/mem_arb_pick.sv - two-way requester pick for the refill arbiter
// Purpose: chooses which cache gets the next line burst.
//   Default: round-robin on a tie (the side that did not go last wins).
//   DCACHE_PRIORITY_EN defined: the D-cache always wins a tie.
// Ports: icReq, dcReq, lastGrant (owner code) -> grant (owner code, OWN_NONE if idle).
module mem_arb_pick
   import mem_arb_pkg::*;
(
   input  logic       icReq,
   input  logic       dcReq,
   input  logic [1:0] lastGrant,
   output logic [1:0] grant
);

   always_comb begin
      grant = OWN_NONE;
      if (icReq && dcReq) begin
`ifdef DCACHE_PRIORITY_EN
         grant = OWN_DC;
`else
         grant = (lastGrant == OWN_DC) ? OWN_IC : OWN_DC;
`endif
      end else if (icReq) begin
         grant = OWN_IC;
      end else if (dcReq) begin
         grant = OWN_DC;
      end
   end

endmodule

// File: rtl/mem_refill_arbiter.sv
// rtl/mem_refill_arbiter.sv - shares one memory word port between I- and D-cache line bursts
// Purpose: IDLE -> BURST -> DONE FSM; grants one cache an exclusive LINE_WORDS burst,
//   streams read words back combinationally on mem_ack, pulses the owner's done.
//   Optional macro DCACHE_PRIORITY_EN (in mem_arb_pick) makes the D-cache win ties.
// Ports: clk, rst_n (async active-low), bus (mem_refill_arbiter_if.master).
module mem_refill_arbiter
   import mem_arb_pkg::*;
#(
   parameter int LINE_WORDS = 8,
   parameter int CNT_W      = 3
) (
   input logic                  clk,
   input logic                  rst_n,
   mem_refill_arbiter_if.master bus
);

   localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(LINE_WORDS - 1);

   logic [1:0]       state;
   logic [CNT_W-1:0] cnt;
   logic [1:0]       owner;
   logic [1:0]       lastGrant;
   logic [31:0]      base;
   logic             isWrite;
   logic [1:0]       grant;

   mem_arb_pick uPick (
      .icReq     (bus.ic_req),
      .dcReq     (bus.dc_req),
      .lastGrant (lastGrant),
      .grant     (grant)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         cnt       <= '0;
         owner     <= OWN_NONE;
         lastGrant <= OWN_DC;
         base      <= '0;
         isWrite   <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (grant != OWN_NONE) begin
                  owner   <= grant;
                  base    <= lineBase((grant == OWN_DC) ? bus.dc_addr : bus.ic_addr, LINE_WORDS);
                  isWrite <= (grant == OWN_DC) && bus.dc_we;
                  cnt     <= '0;
                  state   <= ST_BURST;
               end
            end
            ST_BURST: begin
               if (bus.mem_ack) begin
                  if (cnt == LAST_WORD) begin
                     cnt   <= '0;
                     state <= ST_DONE;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
            end
            ST_DONE: begin
               lastGrant <= owner;
               owner     <= OWN_NONE;
               state     <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   logic inBurst;
   logic wordDone;
   logic icOwns;
   logic dcOwns;

   assign inBurst  = (state == ST_BURST);
   // Ack outside BURST never reaches the caches.
   assign wordDone = inBurst && bus.mem_ack;
   assign icOwns   = (owner == OWN_IC);
   assign dcOwns   = (owner == OWN_DC);

   // cnt only fills the word-offset bits, which lineBase left at zero.
   assign bus.mem_req   = inBurst;
   assign bus.mem_we    = inBurst && isWrite;
   assign bus.mem_addr  = inBurst ? (base | {{(30 - CNT_W){1'b0}}, cnt, 2'b00}) : 32'd0;
   assign bus.mem_wdata = (inBurst && isWrite) ? bus.dc_wdata : 32'd0;

   assign bus.ic_rvalid = wordDone && icOwns;
   assign bus.ic_rdata  = bus.ic_rvalid ? bus.mem_rdata : 32'd0;
   assign bus.dc_rvalid = wordDone && dcOwns && !isWrite;
   assign bus.dc_rdata  = bus.dc_rvalid ? bus.mem_rdata : 32'd0;
   assign bus.dc_wnext  = wordDone && dcOwns && isWrite;

   assign bus.ic_done = (state == ST_DONE) && icOwns;
   assign bus.dc_done = (state == ST_DONE) && dcOwns;
   assign bus.busy    = (state != ST_IDLE);

endmodule

// File: tb/tb_mem_refill_arbiter.sv
// tb/tb_mem_refill_arbiter.sv - directed self-checking bench for mem_refill_arbiter
module tb_mem_refill_arbiter;

   localparam logic [31:0] WDATA0 = 32'hD000_0000;
   localparam logic [31:0] RMASK  = 32'h5A5A_0000;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   errors = 0;
   int   checks = 0;
   bit   scramble = 1'b0;
   int   firstReq;
   int   doneCyc;

   mem_refill_arbiter_if bus ();

   mem_refill_arbiter #(.LINE_WORDS(8), .CNT_W(3)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Memory model: read data is a fixed scramble of the word address.
   assign bus.mem_rdata = bus.mem_addr ^ RMASK;

   task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic checkQuiet(input string tag);
      checkEq({tag, ":mem_req"}, bus.mem_req, 0);
      checkEq({tag, ":mem_addr"}, bus.mem_addr, 0);
      checkEq({tag, ":ic_rvalid"}, bus.ic_rvalid, 0);
      checkEq({tag, ":dc_rvalid"}, bus.dc_rvalid, 0);
      checkEq({tag, ":busy"}, bus.busy, 0);
   endtask

   // Runs one expected burst; returns at the done cycle (before the edge ending it).
   task automatic doBurst(input string name, input int period, input bit isIc,
                          input logic [31:0] base, input bit we,
                          output int firstSeen, output int doneSeen);
      int words = 0;
      int phase = 0;
      bit ack;
      firstSeen = -1;
      doneSeen  = -1;
      for (int cyc = 1; cyc <= 200 && doneSeen < 0; cyc++) begin
         @(negedge clk);
         if (!isIc && we) bus.dc_wdata = WDATA0 + 32'(words);
         if (scramble) begin
            bus.ic_addr = $urandom;
            bus.dc_addr = $urandom;
         end
         if (bus.mem_req && firstSeen < 0) firstSeen = cyc;
         if (bus.mem_req) phase++;
         ack = (period == 1) || (bus.mem_req && (phase % period == 0));
         bus.mem_ack = ack;
         #1;
         checkEq({name, ":ic_rvalid"}, bus.ic_rvalid, ack && bus.mem_req && isIc);
         checkEq({name, ":dc_rvalid"}, bus.dc_rvalid, ack && bus.mem_req && !isIc && !we);
         checkEq({name, ":dc_wnext"}, bus.dc_wnext, ack && bus.mem_req && !isIc && we);
         if (ack && bus.mem_req) begin
            checkEq({name, ":mem_addr"}, bus.mem_addr, base + 32'(words * 4));
            checkEq({name, ":mem_we"}, bus.mem_we, we);
            if (we)
               checkEq({name, ":mem_wdata"}, bus.mem_wdata, WDATA0 + 32'(words));
            else
               checkEq({name, ":rdata"}, isIc ? bus.ic_rdata : bus.dc_rdata,
                       (base + 32'(words * 4)) ^ RMASK);
            words++;
         end
         if (bus.ic_done || bus.dc_done) begin
            checkEq({name, ":ic_done"}, bus.ic_done, isIc);
            checkEq({name, ":dc_done"}, bus.dc_done, !isIc);
            checkEq({name, ":words"}, words, 8);
            doneSeen = cyc;
         end
      end
      checkEq({name, ":done_seen"}, doneSeen > 0, 1);
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic resetDut();
      @(negedge clk);
      rst_n = 1'b0;
      bus.ic_req = 1'b0;
      bus.dc_req = 1'b0;
      bus.mem_ack = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      bus.ic_req = 0; bus.ic_addr = 0; bus.dc_req = 0; bus.dc_we = 0;
      bus.dc_addr = 0; bus.dc_wdata = 0; bus.mem_ack = 0;
      idle(3);
      #1;
      checkQuiet("reset");
      checkEq("reset:ic_done", bus.ic_done, 0);
      checkEq("reset:dc_done", bus.dc_done, 0);
      checkEq("reset:mem_we", bus.mem_we, 0);
      rst_n = 1'b1;

      // 1: I-only refill, zero-wait memory, latency check
      @(negedge clk);
      bus.ic_addr = 32'h0000_1034;
      bus.ic_req  = 1'b1;
      doBurst("t1", 1, 1, 32'h0000_1020, 0, firstReq, doneCyc);
      checkEq("t1:first_req_cycle", firstReq, 1);
      checkEq("t1:done_cycle", doneCyc, 9);
      bus.ic_req = 1'b0;
      bus.mem_ack = 1'b0;
      idle(2);

      // 2: D writeback, ack every 3rd cycle
      bus.dc_we = 1'b1;
      bus.dc_addr = 32'h0000_2000;
      bus.dc_req = 1'b1;
      doBurst("t2", 3, 0, 32'h0000_2000, 1, firstReq, doneCyc);
      bus.dc_req = 1'b0;
      bus.dc_we = 1'b0;
      bus.mem_ack = 1'b0;
      idle(2);

      // 3: simultaneous requests straight after reset
      resetDut();
      bus.ic_addr = 32'h0000_5000;
      bus.dc_addr = 32'h0000_6000;
      bus.ic_req = 1'b1;
      bus.dc_req = 1'b1;
`ifdef DCACHE_PRIORITY_EN
      doBurst("t3d", 1, 0, 32'h0000_6000, 0, firstReq, doneCyc);
      bus.dc_req = 1'b0;
      doBurst("t3i", 1, 1, 32'h0000_5000, 0, firstReq, doneCyc);
      bus.ic_req = 1'b0;
`else
      doBurst("t3i", 1, 1, 32'h0000_5000, 0, firstReq, doneCyc);
      bus.ic_req = 1'b0;
      doBurst("t3d", 1, 0, 32'h0000_6000, 0, firstReq, doneCyc);
      checkEq("t3d:gap", firstReq, 2);
      bus.dc_req = 1'b0;
`endif
      bus.mem_ack = 1'b0;
      idle(2);

      // 4: D keeps requesting with a new line while I joins
      bus.dc_addr = 32'h0000_9000;
      bus.dc_req = 1'b1;
      doBurst("t4a", 1, 0, 32'h0000_9000, 0, firstReq, doneCyc);
      bus.dc_addr = 32'h0000_3000;
      bus.ic_addr = 32'h0000_A010;
      bus.ic_req = 1'b1;
`ifdef DCACHE_PRIORITY_EN
      doBurst("t4d", 1, 0, 32'h0000_3000, 0, firstReq, doneCyc);
      bus.dc_req = 1'b0;
      doBurst("t4i", 1, 1, 32'h0000_A000, 0, firstReq, doneCyc);
      bus.ic_req = 1'b0;
`else
      doBurst("t4i", 1, 1, 32'h0000_A000, 0, firstReq, doneCyc);
      bus.ic_req = 1'b0;
      doBurst("t4d", 1, 0, 32'h0000_3000, 0, firstReq, doneCyc);
      bus.dc_req = 1'b0;
`endif
      bus.mem_ack = 1'b0;
      idle(2);

      // 5: async reset in the middle of a burst
      bus.ic_addr = 32'h0000_1000;
      bus.ic_req = 1'b1;
      bus.mem_ack = 1'b1;
      idle(4);
      #2;
      rst_n = 1'b0;
      bus.ic_req = 1'b0;
      #1;
      checkQuiet("t5_rst");
      checkEq("t5_rst:ic_done", bus.ic_done, 0);
      @(negedge clk);
      rst_n = 1'b1;
      bus.mem_ack = 1'b0;
      bus.ic_addr = 32'h0000_7008;
      bus.ic_req = 1'b1;
      doBurst("t5", 1, 1, 32'h0000_7000, 0, firstReq, doneCyc);
      bus.ic_req = 1'b0;
      idle(2);

      // 6: stray ack while idle, request address churning mid-burst
      bus.mem_ack = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         #1;
         checkQuiet("t6_idle");
      end
      bus.mem_ack = 1'b0;
      bus.ic_addr = 32'h0000_8004;
      bus.ic_req = 1'b1;
      scramble = 1'b1;
      doBurst("t6", 2, 1, 32'h0000_8000, 0, firstReq, doneCyc);
      scramble = 1'b0;
      bus.ic_req = 1'b0;
      bus.mem_ack = 1'b0;
      idle(2);
      #1;
      checkEq("t6:busy_after", bus.busy, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
